fb_scanout: RTL and testbench

Frame-buffer read-side scan-out engine: generates 640x480@60 Hz VGA timing from CLOCK_50 and fetches 8-pixel monochrome words from the frame-buffer RAM. It serializes each word onto the VGA colour outputs. It is the consumer of the FB_ADDR/FB_DATA word format written by the image-processing path: 19-bit pixel address, 8 pixels per byte, 80 words per line.

---
 rtl/fb_scanout_pkg.sv | 71 +++++++
 rtl/vga_timing_gen.sv | 61 ++++++
 rtl/fb_scanout.sv | 139 +++++++++++++
 tb/tb_fb_scanout.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fb_scanout_pkg.sv
// fb_scanout_pkg
//   Shared constants and helpers for the frame-buffer scan-out engine.
//   640x480@60 Hz VGA timing (800x525 total) with a 25 MHz pixel rate
//   derived from a 50 MHz clock. The frame buffer holds 8 monochrome
//   pixels per byte, 80 words per line, addressed by a 19-bit pixel
//   address whose low 3 bits are always zero for a word fetch.
package fb_scanout_pkg;

  localparam int FB_ADDR_W      = 19;
  localparam int PIX_PER_WORD   = 8;
  localparam int WORDS_PER_LINE = 80;
  localparam int WORD_SEL_W     = $clog2(PIX_PER_WORD);

  localparam logic [9:0] H_VISIBLE = 10'(WORDS_PER_LINE * PIX_PER_WORD);
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

  // Counters start two pixels before (0,0) so the first frame is whole
  // and word 0 can be fetched ahead of its first pixel.
  localparam logic [9:0] H_RESET = 10'd798;
  localparam logic [9:0] V_RESET = 10'd524;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
  } pos_t;

  // Raster position one pixel later, including line and frame wrap.
  function automatic pos_t next_pos(input pos_t p);
    pos_t n;
    n = p;
    if (p.h == H_TOTAL - 10'd1) begin
      n.h = 10'd0;
      if (p.v == V_TOTAL - 10'd1) begin
        n.v = 10'd0;
      end else begin
        n.v = p.v + 10'd1;
      end
    end else begin
      n.h = p.h + 10'd1;
    end
    return n;
  endfunction

  // v*640 + h, with the multiply built from two shifts.
  function automatic logic [FB_ADDR_W-1:0] pix_addr(input pos_t p);
    logic [FB_ADDR_W-1:0] v_ext;
    logic [FB_ADDR_W-1:0] h_ext;
    v_ext = {9'd0, p.v};
    h_ext = {9'd0, p.h};
    return (v_ext << 9) + (v_ext << 7) + h_ext;
  endfunction

  function automatic logic is_visible(input pos_t p);
    return (p.h < H_VISIBLE) && (p.v < V_VISIBLE);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Pixel enable and raster counters for 640x480@60 Hz.
//   clk        : 50 MHz system clock
//   rst_n      : synchronous active-low reset
//   pix_en     : high on every other clock; counters advance on those edges
//   pos_p      : position the counters move to at the next pix_en edge
//   pos_n      : position one pixel after pos_p (fetch look-ahead)
//   p_visible  : pos_p lies in the visible area
//   p_hsync_n  : raw active-low horizontal sync for pos_p
//   p_vsync_n  : raw active-low vertical sync for pos_p
//   n_visible  : pos_n lies in the visible area
module vga_timing_gen
  import fb_scanout_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic pix_en,
  output pos_t pos_p,
  output pos_t pos_n,
  output logic p_visible,
  output logic p_hsync_n,
  output logic p_vsync_n,
  output logic n_visible
);

  logic pix_en_r;
  pos_t pos_r;
  pos_t pos_p_s;
  pos_t pos_n_s;

  // Pixel-rate toggle and raster position register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_en_r <= 1'b0;
      pos_r.h  <= H_RESET;
      pos_r.v  <= V_RESET;
    end else begin
      pix_en_r <= ~pix_en_r;
      if (pix_en_r) begin
        pos_r <= pos_p_s;
      end else begin
        pos_r <= pos_r;
      end
    end
  end

  // Look-ahead positions and raw flags for the position being entered.
  always_comb begin
    pos_p_s = next_pos(pos_r);
    pos_n_s = next_pos(pos_p_s);
  end

  assign pix_en    = pix_en_r;
  assign pos_p     = pos_p_s;
  assign pos_n     = pos_n_s;
  assign p_visible = is_visible(pos_p_s);
  assign n_visible = is_visible(pos_n_s);
  assign p_hsync_n = ~((pos_p_s.h >= H_SYNC_START) && (pos_p_s.h <= H_SYNC_END));
  assign p_vsync_n = ~((pos_p_s.v >= V_SYNC_START) && (pos_p_s.v <= V_SYNC_END));

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout
//   Frame-buffer read-side scan-out: VGA 640x480@60 Hz timing, word
//   fetch from the frame-buffer RAM (one-clock read latency) and
//   serialisation of each 8-pixel word, bit 0 leftmost.
//   CLOCK_50    : 50 MHz clock
//   RESET       : synchronous active-low reset
//   FB_DATA     : RAM read data for the previous FB_ADDR
//   TESTPAT     : (only with FB_SCANOUT_TESTPAT_EN) 8x8 checkerboard, no reads
//   FB_ADDR     : pixel address of the word being fetched
//   FB_RD       : one-clock read strobe per fetch
//   VGA_R/G/B   : 8'hFF for a lit pixel, 8'h00 otherwise
//   VGA_HS/VS   : active-low sync
//   VGA_BLANK_N : high in the visible area
//   FRAME_START : one-clock pulse on entering pixel (0,0)
//   Optional feature macro: FB_SCANOUT_TESTPAT_EN
module fb_scanout
  import fb_scanout_pkg::*;
(
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic [7:0]           FB_DATA,
`ifdef FB_SCANOUT_TESTPAT_EN
  input  logic                 TESTPAT,
`endif
  output logic [FB_ADDR_W-1:0] FB_ADDR,
  output logic                 FB_RD,
  output logic [7:0]           VGA_R,
  output logic [7:0]           VGA_G,
  output logic [7:0]           VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK_N,
  output logic                 FRAME_START
);

  logic pix_en_s;
  pos_t pos_p_s;
  pos_t pos_n_s;
  logic p_visible_s;
  logic p_hsync_n_s;
  logic p_vsync_n_s;
  logic n_visible_s;

  logic       testpat_s;
  logic       fetch_pos_s;
  logic       load_s;
  logic [7:0] shift_nxt_s;
  logic       lit_s;

  logic [FB_ADDR_W-1:0] fb_addr_r;
  logic                 fb_rd_r;
  logic [7:0]           shift_r;
  logic [7:0]           rgb_r;
  logic                 hs_r;
  logic                 vs_r;
  logic                 blank_n_r;
  logic                 frame_start_r;

  vga_timing_gen u_timing (
    .clk       (CLOCK_50),
    .rst_n     (RESET),
    .pix_en    (pix_en_s),
    .pos_p     (pos_p_s),
    .pos_n     (pos_n_s),
    .p_visible (p_visible_s),
    .p_hsync_n (p_hsync_n_s),
    .p_vsync_n (p_vsync_n_s),
    .n_visible (n_visible_s)
  );

`ifdef FB_SCANOUT_TESTPAT_EN
  assign testpat_s = TESTPAT;
`else
  assign testpat_s = 1'b0;
`endif

  // Fetch decision for the pixel after the one being entered, and the
  // next value of the serialiser word.
  always_comb begin
    fetch_pos_s = n_visible_s &&
                  (pos_n_s.h[WORD_SEL_W-1:0] == {WORD_SEL_W{1'b0}});
    load_s      = (pos_p_s.h[WORD_SEL_W-1:0] == {WORD_SEL_W{1'b0}});
    if (load_s) begin
      shift_nxt_s = FB_DATA;
    end else begin
      shift_nxt_s = {1'b0, shift_r[7:1]};
    end
    if (testpat_s) begin
      lit_s = pos_p_s.h[3] ^ pos_p_s.v[3];
    end else begin
      lit_s = shift_nxt_s[0];
    end
  end

  // Fetch, serialiser and output registers; strobes last a single clock.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      fb_addr_r     <= {FB_ADDR_W{1'b0}};
      fb_rd_r       <= 1'b0;
      shift_r       <= 8'h00;
      rgb_r         <= 8'h00;
      hs_r          <= 1'b1;
      vs_r          <= 1'b1;
      blank_n_r     <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (pix_en_s) begin
      if (fetch_pos_s) begin
        fb_addr_r <= pix_addr(pos_n_s);
      end else begin
        fb_addr_r <= fb_addr_r;
      end
      fb_rd_r <= fetch_pos_s & ~testpat_s;
      if (p_visible_s) begin
        shift_r <= shift_nxt_s;
      end else begin
        shift_r <= shift_r;
      end
      rgb_r         <= (p_visible_s && lit_s) ? 8'hFF : 8'h00;
      hs_r          <= p_hsync_n_s;
      vs_r          <= p_vsync_n_s;
      blank_n_r     <= p_visible_s;
      frame_start_r <= (pos_p_s.h == 10'd0) && (pos_p_s.v == 10'd0);
    end else begin
      fb_rd_r       <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

  assign FB_ADDR     = fb_addr_r;
  assign FB_RD       = fb_rd_r;
  assign VGA_R       = rgb_r;
  assign VGA_G       = rgb_r;
  assign VGA_B       = rgb_r;
  assign VGA_HS      = hs_r;
  assign VGA_VS      = vs_r;
  assign VGA_BLANK_N = blank_n_r;
  assign FRAME_START = frame_start_r;

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout
//   Self-checking bench for fb_scanout. A random frame-buffer image is
//   served by a one-clock-latency RAM model; every clock the outputs are
//   compared with a reference derived from the raster position, which is
//   computed directly from the number of clock edges since reset release.
//   Optional feature macro: FB_SCANOUT_TESTPAT_EN (adds a checkerboard phase).
module tb_fb_scanout;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        testpat;
  logic [7:0]  fb_data;
  logic [18:0] fb_addr;
  logic        fb_rd;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;
  logic        frame_start;

  logic [7:0]  mem [0:38399];

  int n_checks  = 0;
  int n_errors  = 0;
  int k         = 0;   // clock edges since reset release
  int exp_addr  = 0;
  int hs_low_cnt;
  int rd_cnt;
  int fs_cnt;

  always #10 clk = ~clk;

  fb_scanout dut (
    .CLOCK_50    (clk),
    .RESET       (reset_n),
    .FB_DATA     (fb_data),
`ifdef FB_SCANOUT_TESTPAT_EN
    .TESTPAT     (testpat),
`endif
    .FB_ADDR     (fb_addr),
    .FB_RD       (fb_rd),
    .VGA_R       (vga_r),
    .VGA_G       (vga_g),
    .VGA_B       (vga_b),
    .VGA_HS      (vga_hs),
    .VGA_VS      (vga_vs),
    .VGA_BLANK_N (vga_blank_n),
    .FRAME_START (frame_start)
  );

  // Frame-buffer RAM: samples the address every clock, data one clock later.
  always @(posedge clk) begin
    fb_data <= (fb_addr[18:3] < 16'd38400) ? mem[fb_addr[18:3]] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  // Raster position after m pixel steps, starting from (798,524).
  function automatic int pos_lin(int m);
    return (524 * 800 + 798 + m) % 420000;
  endfunction
  function automatic int pos_h(int m);
    return pos_lin(m) % 800;
  endfunction
  function automatic int pos_v(int m);
    return pos_lin(m) / 800;
  endfunction

  task automatic compare_outputs();
    int   m, h, v, nh, nv, a;
    bit   vis, nvis, pix_edge, lit;
    logic e_hs, e_vs, e_blank, e_rd, e_fs;
    logic [7:0] e_rgb;
    m = k / 2;
    if (m == 0) begin
      e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_rgb = 8'h00;
      e_rd = 1'b0; e_fs = 1'b0;
    end else begin
      h        = pos_h(m);
      v        = pos_v(m);
      nh       = pos_h(m + 1);
      nv       = pos_v(m + 1);
      vis      = (h < 640) && (v < 480);
      nvis     = (nh < 640) && (nv < 480);
      pix_edge = (k % 2) == 0;
      if (!vis) begin
        lit = 1'b0;
      end else if (testpat) begin
        lit = (((h / 8) + (v / 8)) % 2) == 1;
      end else begin
        a   = v * 640 + h;
        lit = mem[a / 8][a % 8];
      end
      e_hs    = !((h >= 656) && (h <= 751));
      e_vs    = !((v >= 490) && (v <= 491));
      e_blank = vis;
      e_rgb   = lit ? 8'hFF : 8'h00;
      e_rd    = pix_edge && !testpat && nvis && ((nh % 8) == 0);
      e_fs    = pix_edge && (h == 0) && (v == 0);
    end
    check("vga_hs",      32'(vga_hs),      32'(e_hs));
    check("vga_vs",      32'(vga_vs),      32'(e_vs));
    check("vga_blank_n", 32'(vga_blank_n), 32'(e_blank));
    check("vga_r",       32'(vga_r),       32'(e_rgb));
    check("vga_g",       32'(vga_g),       32'(e_rgb));
    check("vga_b",       32'(vga_b),       32'(e_rgb));
    check("fb_rd",       32'(fb_rd),       32'(e_rd));
    check("fb_addr",     32'(fb_addr),     32'(exp_addr));
    check("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  // One clock edge with the given reset level, then a check on the falling edge.
  task automatic tick(input logic rst_val);
    int nh, nv;
    reset_n = rst_val;
    @(posedge clk);
    if (rst_val) k = k + 1; else k = 0;
    if (k == 0) begin
      exp_addr = 0;
    end else if ((k % 2) == 0) begin
      nh = pos_h(k / 2 + 1);
      nv = pos_v(k / 2 + 1);
      if ((nh < 640) && (nv < 480) && ((nh % 8) == 0)) exp_addr = nv * 640 + nh;
    end
    @(negedge clk);
    compare_outputs();
    if (k >= 2 && k <= 1601) begin
      if (!vga_hs)     hs_low_cnt++;
      if (fb_rd)       rd_cnt++;
      if (frame_start) fs_cnt++;
    end
  endtask

  // Release reset and run through the first full line of the new frame.
  task automatic release_and_check_line0();
    hs_low_cnt = 0;
    rd_cnt     = 0;
    fs_cnt     = 0;
    while (k < 1602) tick(1'b1);
    check("hs_low_clocks",      32'(hs_low_cnt), 32'd192);
    check("fetches_line0",      32'(rd_cnt),     testpat ? 32'd0 : 32'd80);
    check("frame_start_pulses", 32'(fs_cnt),     32'd1);
  endtask

  initial begin
    int h_rst;
    int guard;
    testpat = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 38400; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'h01;

    repeat (5) tick(1'b0);
    release_and_check_line0();

    // Mid-frame reset for one clock somewhere on line 2.
    h_rst = $urandom_range(100, 700);
    guard = 0;
    while (!(((k % 2) == 0) && (pos_h(k / 2) == h_rst) && (pos_v(k / 2) == 2)) &&
           (guard < 10000)) begin
      tick(1'b1);
      guard++;
    end
    check("reach_reset_point", 32'(guard < 10000), 32'd1);
    tick(1'b0);
    release_and_check_line0();
    repeat (1700) tick(1'b1);

`ifdef FB_SCANOUT_TESTPAT_EN
    testpat = 1'b1;
    repeat (3) tick(1'b0);
    release_and_check_line0();
    repeat (900) tick(1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
